// File: rtl/peripheral_bus_n.sv
// N-slave peripheral interconnect: windowed decode, base-relative addressing,
// error response on unmapped addresses and a per-transaction timeout.
module peripheral_bus_n #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] START_ADDRESSES =
        {32'h000013BB, 32'h00001003, 32'h00001000, 32'h00000000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] FINAL_ADDRESSES =
        {32'h000013BE, 32'h000013BA, 32'h00001002, 32'h00000FFF},
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA = 32'hDEADBEEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             read_request,
    input  logic                             write_request,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic [DATA_WIDTH-1:0]            write_data,
    output logic                             response,
    output logic                             error,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic [NUM_SLAVES-1:0]            slave_read,
    output logic [NUM_SLAVES-1:0]            slave_write,
    input  logic [NUM_SLAVES-1:0]            slave_response,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
    output logic [ADDR_WIDTH-1:0]            slave_address,
    output logic [DATA_WIDTH-1:0]            slave_write_data
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;
    localparam logic [1:0] ERROR   = 2'd3;

    logic [1:0]            state;
    logic [SW-1:0]         sel;
    logic                  op_write;
    logic [CW-1:0]         count;
    logic [NUM_SLAVES-1:0] sel_mask;

    logic                  hit;
    logic [SW-1:0]         hit_idx;
    logic [ADDR_WIDTH-1:0] hit_rel;

    // Scan from the top so the lowest matching window is the last to win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_rel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (address >= START_ADDRESSES[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                address <= FINAL_ADDRESSES[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
                hit_rel = address - START_ADDRESSES[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign sel_mask    = NUM_SLAVES'(1) << sel;
    assign slave_read  = (state == ACCESS && !op_write) ? sel_mask : '0;
    assign slave_write = (state == ACCESS &&  op_write) ? sel_mask : '0;
    assign response    = (state == RESPOND) || (state == ERROR);
    assign error       = (state == ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            sel              <= '0;
            op_write         <= 1'b0;
            count            <= '0;
            read_data        <= '0;
            slave_address    <= '0;
            slave_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_request || write_request) begin
                        op_write         <= write_request;
                        slave_write_data <= write_data;
                        count            <= '0;
                        if (hit) begin
                            sel           <= hit_idx;
                            slave_address <= hit_rel;
                            state         <= ACCESS;
                        end else begin
                            read_data <= ERROR_DATA;
                            state     <= ERROR;
                        end
                    end
                end
                ACCESS: begin
                    count <= count + 1'b1;
                    // A response on the last timeout cycle still succeeds.
                    if (slave_response[sel]) begin
                        read_data <= slave_read_data[sel*DATA_WIDTH +: DATA_WIDTH];
                        state     <= RESPOND;
                    end else if (TIMEOUT_CYCLES != 0 &&
                                 count == CW'(TIMEOUT_CYCLES - 1)) begin
                        read_data <= ERROR_DATA;
                        state     <= ERROR;
                    end
                end
                RESPOND: state <= IDLE;
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bus_n.sv
// Scoreboard bench for peripheral_bus_n: 8 slaves with overlapping windows,
// timeout of 4, directed cases followed by randomized traffic.
module tb_peripheral_bus_n;

    localparam int NS = 8;
    localparam int TO = 4;
    localparam logic [NS*32-1:0] STARTS = {
        32'hFFFF0000, 32'h00008080, 32'h00008000, 32'h00004000,
        32'h000013BB, 32'h00001003, 32'h00001000, 32'h00000000};
    localparam logic [NS*32-1:0] FINALS = {
        32'hFFFFFFFF, 32'h000081FF, 32'h000080FF, 32'h00004FFF,
        32'h000013BE, 32'h000013BA, 32'h00001002, 32'h00000FFF};

    logic [31:0] m_start [NS] = '{32'h00000000, 32'h00001000, 32'h00001003,
        32'h000013BB, 32'h00004000, 32'h00008000, 32'h00008080, 32'hFFFF0000};
    logic [31:0] m_final [NS] = '{32'h00000FFF, 32'h00001002, 32'h000013BA,
        32'h000013BE, 32'h00004FFF, 32'h000080FF, 32'h000081FF, 32'hFFFFFFFF};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_request = 1'b0;
    logic          write_request = 1'b0;
    logic [31:0]   address = '0;
    logic [31:0]   write_data = '0;
    logic          response;
    logic          error;
    logic [31:0]   read_data;
    logic [NS-1:0] slave_read;
    logic [NS-1:0] slave_write;
    logic [NS-1:0] slave_response = '0;
    logic [NS*32-1:0] slave_read_data = '0;
    logic [31:0]   slave_address;
    logic [31:0]   slave_write_data;

    peripheral_bus_n #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .NUM_SLAVES(NS),
        .START_ADDRESSES(STARTS),
        .FINAL_ADDRESSES(FINALS),
        .TIMEOUT_CYCLES(TO),
        .ERROR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .read_request(read_request),
        .write_request(write_request),
        .address(address),
        .write_data(write_data),
        .response(response),
        .error(error),
        .read_data(read_data),
        .slave_read(slave_read),
        .slave_write(slave_write),
        .slave_response(slave_response),
        .slave_read_data(slave_read_data),
        .slave_address(slave_address),
        .slave_write_data(slave_write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] rd_mask;
        logic [NS-1:0] wr_mask;
        logic [31:0]   rel;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        logic          err;
        bit            chk_rd;
        int            cycles;
    } exp_t;

    exp_t sbq [$];
    int   tests = 0;
    int   fails = 0;
    int   strobe_cnt = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void decode(input logic [31:0] a,
                                   output bit h, output int idx);
        h = 0;
        idx = 0;
        for (int i = 0; i < NS; i++)
            if (!h && a >= m_start[i] && a <= m_final[i]) begin
                h = 1;
                idx = i;
            end
    endfunction

    // Monitor: checks strobes every cycle and pops on each response pulse.
    always @(negedge clk) begin
        if (reset) begin
            strobe_cnt = 0;
        end else begin
            if (|slave_read || |slave_write) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", {slave_read, slave_write}, 0);
                end else begin
                    chk("slave_read", slave_read, sbq[0].rd_mask);
                    chk("slave_write", slave_write, sbq[0].wr_mask);
                    chk("slave_address", slave_address, sbq[0].rel);
                    if (sbq[0].wr_mask != 0)
                        chk("slave_write_data", slave_write_data, sbq[0].wdata);
                end
                strobe_cnt++;
            end
            if (response) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_response", response, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("error", error, e.err);
                    if (e.chk_rd) chk("read_data", read_data, e.rdata);
                    chk("strobe_cycles", strobe_cnt, e.cycles);
                end
                strobe_cnt = 0;
            end
        end
    end

    // lat = strobe cycle in which the selected slave answers (>TO: never in time)
    task automatic xact(bit rd, bit wr, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] d, int lat);
        exp_t e;
        bit h;
        int idx;
        int cnt;
        bit done;
        logic [31:0] sd [NS];
        logic [NS-1:0] sr;
        decode(a, h, idx);
        for (int i = 0; i < NS; i++) sd[i] = $urandom;
        sd[idx] = d;
        e.rd_mask = (h && !wr) ? NS'(1) << idx : '0;
        e.wr_mask = (h && wr) ? NS'(1) << idx : '0;
        e.rel = a - m_start[idx];
        e.wdata = wd;
        e.chk_rd = !wr || !h || lat > TO;
        if (!h) begin
            e.err = 1'b1;
            e.rdata = 32'hDEADBEEF;
            e.cycles = 0;
        end else if (lat >= 1 && lat <= TO) begin
            e.err = 1'b0;
            e.rdata = d;
            e.cycles = lat;
        end else begin
            e.err = 1'b1;
            e.rdata = 32'hDEADBEEF;
            e.cycles = TO;
        end
        sbq.push_back(e);
        @(negedge clk);
        read_request = rd;
        write_request = wr;
        address = a;
        write_data = wd;
        for (int i = 0; i < NS; i++) slave_read_data[i*32 +: 32] = sd[i];
        @(posedge clk);
        #1;
        read_request = 1'b0;
        write_request = 1'b0;
        cnt = 0;
        done = 0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            sr = NS'($urandom) & ~(NS'(1) << idx);
            if (h && (slave_read[idx] || slave_write[idx])) begin
                cnt++;
                if (cnt == lat) sr[idx] = 1'b1;
            end
            slave_response = sr;
            if (response) done = 1;
        end
        slave_response = '0;
        if (!done) chk("response_timeout", 0, 1);
    endtask

    task automatic reset_mid_access();
        exp_t e;
        e.rd_mask = 8'h02;
        e.wr_mask = '0;
        e.rel = 32'h1;
        e.wdata = '0;
        e.rdata = '0;
        e.err = 1'b0;
        e.chk_rd = 0;
        e.cycles = 0;
        sbq.push_back(e);
        @(negedge clk);
        read_request = 1'b1;
        address = 32'h00001001;
        @(posedge clk);
        #1;
        read_request = 1'b0;
        chk("pre_reset_strobe", slave_read, 8'h02);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("rst_outputs", {response, error, slave_read, slave_write}, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_slave_addr", slave_address, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", {response, slave_read, slave_write}, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {response, error, slave_read, slave_write}, 0);
        chk("reset_read_data", read_data, 0);
        chk("reset_slave_addr", slave_address, 0);
        chk("reset_slave_wdata", slave_write_data, 0);
        reset = 1'b0;

        xact(1, 0, 32'h00001001, 32'h0, 32'hCAFE0001, 3);
        xact(0, 1, 32'h000013BC, 32'h12345678, 32'h0, 2);
        xact(1, 0, 32'h00002000, 32'h0, 32'h0, 1);
        xact(1, 0, 32'h00000010, 32'h0, 32'h0, 99);
        xact(1, 1, 32'h00000004, 32'hA5A5A5A5, 32'h0, 1);
        xact(1, 0, 32'h00008010, 32'h0, 32'h55AA0010, 1);
        xact(1, 0, 32'h00008090, 32'h0, 32'h55AA0090, 2);
        xact(0, 1, 32'h00008100, 32'h0BADF00D, 32'h0, 3);
        xact(1, 0, 32'h00004000, 32'h0, 32'h44440000, TO);
        xact(1, 0, 32'h00004FFF, 32'h0, 32'h44440FFF, TO + 1);
        xact(1, 0, 32'h00000FFF, 32'h0, 32'h00000FFF, 1);
        xact(1, 0, 32'h00001000, 32'h0, 32'h00001000, 2);
        xact(1, 0, 32'h000013BE, 32'h0, 32'h000013BE, 1);
        xact(1, 0, 32'h000013BF, 32'h0, 32'h0, 1);
        xact(1, 0, 32'hFFFFFFFF, 32'h0, 32'h7777FFFF, 1);
        reset_mid_access();
        xact(1, 0, 32'h00001001, 32'h0, 32'hCAFE0002, 1);

        for (int k = 0; k < 150; k++) begin
            int w;
            logic [31:0] a;
            logic [31:0] sz;
            bit rd;
            bit wr;
            w = $urandom_range(NS - 1, 0);
            sz = m_final[w] - m_start[w] + 1;
            case ($urandom_range(3, 0))
                0: a = m_start[w] + ($urandom % sz);
                1: a = ($urandom_range(1, 0) == 1) ? m_final[w] + 1 : m_start[w] - 1;
                2: a = m_start[w];
                default: a = $urandom;
            endcase
            rd = $urandom_range(1, 0) == 1;
            wr = !rd || ($urandom_range(3, 0) == 0);
            xact(rd, wr, a, $urandom, $urandom, $urandom_range(TO + 2, 1));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
